// File: rtl/hello_cpu_0_oci_dct_pkg.sv
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_dct_pkg
// Shared definitions for the OCI data-capture-trace (DCT) packer:
//   ATOM_W / SLOTS / BUF_W / CNT_W  - atom and buffer geometry
//   dct_state_e                     - packer FSM states (RUN, DRAIN, DONE)
//   ATOM_*                          - atom encodings (atoms are stored verbatim)
//   slot_write()                    - replaces one atom slot inside a packed buffer
// ---------------------------------------------------------------------------
package hello_cpu_0_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int BUF_W  = ATOM_W * SLOTS;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_e;

  localparam logic [ATOM_W-1:0] ATOM_0 = 2'b00;
  localparam logic [ATOM_W-1:0] ATOM_1 = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_2 = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_3 = 2'b11;

  // Slot k occupies bits [ATOM_W*k +: ATOM_W]; an out-of-range k leaves b untouched.
  function automatic logic [BUF_W-1:0] slot_write(input logic [BUF_W-1:0]  b,
                                                  input logic [CNT_W-1:0]  k,
                                                  input logic [ATOM_W-1:0] a);
    logic [BUF_W-1:0] r;
    r = b;
    for (int s = 0; s < SLOTS; s++) begin
      if (k == s[CNT_W-1:0]) r[s*ATOM_W +: ATOM_W] = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/hello_cpu_0_oci_dct_packer_if.sv
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_dct_packer_if
// Bundles the atom input handshake, the control requests, the DCT output
// handshake and the end-of-test status of the packer.
//   master : packer side (consumes atoms/requests, drives dct_* and status)
//   slave  : environment side (atom producer + trace consumer)
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high; the offering side holds its payload
// stable until that edge, and ready never depends combinationally on valid.
// dbg_state exposes the packer FSM state for observation.
// ---------------------------------------------------------------------------
interface hello_cpu_0_oci_dct_packer_if;
  import hello_cpu_0_oci_dct_pkg::*;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom;
  logic              atom_ready;
  logic              flush;
  logic              end_req;
  logic              dct_valid;
  logic              dct_ready;
  logic [BUF_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              test_ending;
  logic              test_has_ended;
  dct_state_e        dbg_state;

  modport master (
    input  atom_valid, atom, flush, end_req, dct_ready,
    output atom_ready, dct_valid, dct_buffer, dct_count,
           test_ending, test_has_ended, dbg_state
  );

  modport slave (
    output atom_valid, atom, flush, end_req, dct_ready,
    input  atom_ready, dct_valid, dct_buffer, dct_count,
           test_ending, test_has_ended, dbg_state
  );

endinterface

// File: rtl/hello_cpu_0_oci_dct_outreg.sv
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_dct_outreg
// Output holding register for finished DCT buffers.
//   clk, reset_n  clock / asynchronous active-low reset
//   i_load        capture i_buf/i_cnt and raise o_valid (only when o_free)
//   i_buf, i_cnt  packed atoms and atom count to present
//   i_ready       consumer ready
//   o_valid       payload valid; o_buf/o_cnt held while o_valid && !i_ready
//   o_free        register may be loaded this cycle (empty or draining now)
// ---------------------------------------------------------------------------
module hello_cpu_0_oci_dct_outreg
  import hello_cpu_0_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [BUF_W-1:0] i_buf,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [BUF_W-1:0] o_buf,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_free
);

  logic             r_valid;
  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_buf   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      // A load in the handshake cycle makes the beats back-to-back.
      r_valid <= 1'b1;
      r_buf   <= i_buf;
      r_cnt   <= i_cnt;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_buf   = r_buf;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/hello_cpu_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// hello_cpu_0_oci_dct_packer
// Packs 2-bit trace atoms into 30-bit buffers (15 slots, slot k at [2k+1:2k])
// and hands them out with an atom count over a valid/ready handshake. Runs the
// end-of-test sequence RUN -> DRAIN -> DONE once all trace has been delivered.
//   clk, reset_n  clock / asynchronous active-low reset
//   bus (master)  atom_valid/atom/atom_ready, flush, end_req,
//                 dct_valid/dct_ready/dct_buffer/dct_count,
//                 test_ending, test_has_ended, dbg_state
// Optional feature: define DCT_TIMEOUT_EN to auto-flush a partial buffer after
// TIMEOUT_CYCLES idle cycles; without it partial buffers leave only on
// flush or end_req.
// ---------------------------------------------------------------------------
module hello_cpu_0_oci_dct_packer
  import hello_cpu_0_oci_dct_pkg::*;
`ifdef DCT_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 64
)
`endif
(
  input logic                           clk,
  input logic                           reset_n,
  hello_cpu_0_oci_dct_packer_if.master  bus
);

  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

  dct_state_e       r_state;
  logic [BUF_W-1:0] r_pack_buf;
  logic [CNT_W-1:0] r_pack_cnt;
  logic             r_flush_pend;
  logic             r_test_ending;
  logic             r_test_has_ended;

  logic             w_atom_ready;
  logic             w_accept;
  logic             w_out_free;
  logic             w_xfer;
  logic             w_flush_set;
  logic             w_timeout_hit;
  logic [BUF_W-1:0] w_buf_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pend_nxt;
  logic             w_dct_valid;
  logic [BUF_W-1:0] w_dct_buffer;
  logic [CNT_W-1:0] w_dct_count;

  // Ready is built from registered state only; gating with reset_n keeps it
  // low while reset is held.
  assign w_atom_ready = reset_n && (r_state == ST_RUN) && (r_pack_cnt < SLOTS_C);
  assign w_accept     = bus.atom_valid && w_atom_ready;
  assign w_xfer       = w_out_free &&
                        ((r_pack_cnt == SLOTS_C) || ((r_pack_cnt != '0) && r_flush_pend));

  // The pack is cleared on transfer first, so an atom accepted in the
  // transfer cycle lands in slot 0 of the fresh pack.
  always_comb begin
    w_buf_nxt = r_pack_buf;
    w_cnt_nxt = r_pack_cnt;
    if (w_xfer) begin
      w_buf_nxt = '0;
      w_cnt_nxt = '0;
    end
    if (w_accept) begin
      w_buf_nxt = slot_write(w_buf_nxt, w_cnt_nxt, bus.atom);
      w_cnt_nxt = w_cnt_nxt + 1'b1;
    end
  end

  assign w_flush_set = (bus.flush && (r_state != ST_DONE)) ||
                       (bus.end_req && (r_state == ST_RUN)) ||
                       w_timeout_hit;
  // A pending flush never survives an empty pack, so no zero-count beat exists.
  assign w_pend_nxt  = ((r_flush_pend && !w_xfer) || w_flush_set) && (w_cnt_nxt != '0);

`ifdef DCT_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_nxt;

  always_comb begin
    w_idle_nxt = r_idle_cnt;
    if (w_accept || w_xfer || (r_pack_cnt == '0)) w_idle_nxt = '0;
    else if (r_idle_cnt != IDLE_MAX)              w_idle_nxt = r_idle_cnt + 1'b1;
  end

  assign w_timeout_hit = (w_idle_nxt == IDLE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_idle_cnt <= '0;
    else          r_idle_cnt <= w_idle_nxt;
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pack_buf   <= '0;
      r_pack_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_pack_buf   <= w_buf_nxt;
      r_pack_cnt   <= w_cnt_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_RUN;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.end_req) begin
            r_state       <= ST_DRAIN;
            r_test_ending <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Done only once the pack is empty and the last beat was taken.
          if ((r_pack_cnt == '0) && !w_dct_valid) begin
            r_state          <= ST_DONE;
            r_test_has_ended <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  hello_cpu_0_oci_dct_outreg u_outreg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_xfer),
    .i_buf   (r_pack_buf),
    .i_cnt   (r_pack_cnt),
    .i_ready (bus.dct_ready),
    .o_valid (w_dct_valid),
    .o_buf   (w_dct_buffer),
    .o_cnt   (w_dct_count),
    .o_free  (w_out_free)
  );

  assign bus.atom_ready     = w_atom_ready;
  assign bus.dct_valid      = w_dct_valid;
  assign bus.dct_buffer     = w_dct_buffer;
  assign bus.dct_count      = w_dct_count;
  assign bus.test_ending    = r_test_ending;
  assign bus.test_has_ended = r_test_has_ended;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_hello_cpu_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_hello_cpu_0_oci_dct_packer
// Directed bench for the DCT packer: reset values, full-buffer packing,
// flush, back-pressure with back-to-back beats, idle timeout (or its absence),
// the end-of-test sequence and an asynchronous mid-operation reset.
// Delivered beats are collected as {count, buffer} and matched against
// hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_hello_cpu_0_oci_dct_packer;
  import hello_cpu_0_oci_dct_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hello_cpu_0_oci_dct_packer_if bus();

  hello_cpu_0_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [CNT_W+BUF_W-1:0] got_q[$];
  logic [CNT_W+BUF_W-1:0] exp_q[$];

  // Beat collector: values seen here are the pre-edge values of the handshake.
  always @(posedge clk) begin
    if (reset_n && bus.dct_valid && bus.dct_ready)
      got_q.push_back({bus.dct_count, bus.dct_buffer});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    bus.atom_valid = 1'b0;
    bus.atom       = '0;
    bus.flush      = 1'b0;
    bus.end_req    = 1'b0;
    bus.dct_ready  = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    init_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    got_q.delete();
  endtask

  // Offers one atom and returns once it has been accepted; stalls counts the
  // cycles atom_ready was low while offering.
  task automatic offer(input logic [ATOM_W-1:0] a, output int stalls);
    stalls = 0;
    bus.atom_valid = 1'b1;
    bus.atom       = a;
    while (!bus.atom_ready && stalls < 200) begin
      tick();
      stalls++;
    end
    checks++;
    if (stalls >= 200) begin
      errors++;
      $display("FAIL offer_timeout atom_ready stuck low got=%0b exp=1", bus.atom_ready);
    end
    tick();
    bus.atom_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 200 && got_q.size() < n; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    init_inputs();
    repeat (2) tick();
    checks++; if (bus.dct_valid !== 1'b0) begin errors++; $display("FAIL reset_dct_valid got=%0b exp=0", bus.dct_valid); end
    checks++; if (bus.dct_count !== 4'd0) begin errors++; $display("FAIL reset_dct_count got=%0d exp=0", bus.dct_count); end
    checks++; if (bus.dct_buffer !== 30'd0) begin errors++; $display("FAIL reset_dct_buffer got=%h exp=0", bus.dct_buffer); end
    checks++; if (bus.atom_ready !== 1'b0) begin errors++; $display("FAIL reset_atom_ready got=%0b exp=0", bus.atom_ready); end
    checks++; if (bus.test_ending !== 1'b0) begin errors++; $display("FAIL reset_test_ending got=%0b exp=0", bus.test_ending); end
    checks++; if (bus.test_has_ended !== 1'b0) begin errors++; $display("FAIL reset_test_has_ended got=%0b exp=0", bus.test_has_ended); end
    reset_n = 1'b1;
    tick();
    checks++; if (bus.atom_ready !== 1'b1) begin errors++; $display("FAIL post_reset_atom_ready got=%0b exp=1", bus.atom_ready); end
    checks++; if (bus.dbg_state !== ST_RUN) begin errors++; $display("FAIL post_reset_state got=%0d exp=%0d", bus.dbg_state, ST_RUN); end
  endtask

  task automatic test_full_buffer();
    int st;
    int total;
    logic [CNT_W+BUF_W-1:0] e, g;
    total = 0;
    bus.dct_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      offer(ATOM_1, st);
      total += st;
    end
    checks++; if (total != 0) begin errors++; $display("FAIL full_fill_stalls got=%0d exp=0", total); end
    checks++; if (bus.atom_ready !== 1'b0) begin errors++; $display("FAIL full_bubble_ready got=%0b exp=0", bus.atom_ready); end
    checks++; if (bus.dct_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got=%0b exp=0", bus.dct_valid); end
    tick();
    checks++; if (bus.atom_ready !== 1'b1) begin errors++; $display("FAIL full_bubble_end_ready got=%0b exp=1", bus.atom_ready); end
    checks++; if (bus.dct_valid !== 1'b1) begin errors++; $display("FAIL full_latency_valid got=%0b exp=1", bus.dct_valid); end
    checks++; if (bus.dct_count !== 4'd15) begin errors++; $display("FAIL full_count got=%0d exp=15", bus.dct_count); end
    checks++; if (bus.dct_buffer !== 30'h15555555) begin errors++; $display("FAIL full_buffer got=%h exp=15555555", bus.dct_buffer); end
    exp_q.push_back({4'd15, 30'h15555555});
    wait_beats(1);
    repeat (3) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL full_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_flush();
    int st;
    logic [CNT_W+BUF_W-1:0] e, g;
    offer(ATOM_1, st);
    offer(ATOM_2, st);
    offer(ATOM_3, st);
    pulse_flush();
    exp_q.push_back({4'd3, 30'h00000039});
    wait_beats(1);
    repeat (3) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL flush_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    // Flush on an empty pack must not produce a beat.
    pulse_flush();
    repeat (20) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL flush_empty_beats got=%0d exp=0", got_q.size()); end
    checks++; if (bus.dct_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid got=%0b exp=0", bus.dct_valid); end
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [ATOM_W-1:0] vals[40];
    logic [BUF_W-1:0] word;
    logic [BUF_W-1:0] hold_buf;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W+BUF_W-1:0] beat1, e, g;
    logic have;
    logic rdy;
    int sent;
    int unstable;
    int n;
    for (int i = 0; i < 40; i++) vals[i] = ATOM_W'(i % 4);
    for (int b = 0; b < 3; b++) begin
      word = '0;
      n = (b < 2) ? 15 : 10;
      for (int k = 0; k < n; k++) word[2*k +: 2] = vals[b*15 + k];
      exp_q.push_back({CNT_W'(n), word});
    end
    beat1 = exp_q[0];
    sent = 0; unstable = 0; have = 1'b0;
    hold_buf = '0; hold_cnt = '0;
    bus.dct_ready = 1'b0;
    for (int c = 0; c < 60; c++) begin
      bus.atom_valid = (sent < 40);
      bus.atom = vals[sent % 40];
      rdy = bus.atom_ready;
      if (bus.dct_valid) begin
        if (!have) begin
          hold_buf = bus.dct_buffer; hold_cnt = bus.dct_count; have = 1'b1;
        end else if (bus.dct_buffer !== hold_buf || bus.dct_count !== hold_cnt) begin
          unstable++;
        end
      end
      tick();
      if (rdy && sent < 40) sent++;
    end
    checks++; if (sent != 30) begin errors++; $display("FAIL bp_accepted got=%0d exp=30", sent); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold_stable got=%0d changes exp=0", unstable); end
    checks++; if ({hold_cnt, hold_buf} !== beat1) begin errors++; $display("FAIL bp_held_beat got=%h exp=%h", {hold_cnt, hold_buf}, beat1); end
    bus.dct_ready = 1'b1;
    for (int c = 0; c < 100 && sent < 40; c++) begin
      bus.atom_valid = 1'b1;
      bus.atom = vals[sent];
      rdy = bus.atom_ready;
      tick();
      if (rdy) sent++;
    end
    bus.atom_valid = 1'b0;
    checks++; if (sent != 40) begin errors++; $display("FAIL bp_all_accepted got=%0d exp=40", sent); end
    pulse_flush();
    wait_beats(3);
    repeat (3) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_beat got=%h exp=%h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout();
    int st;
    logic [CNT_W+BUF_W-1:0] g;
    bus.dct_ready = 1'b1;
    offer(ATOM_2, st);
`ifdef DCT_TIMEOUT_EN
    for (int c = 0; c < 66 && got_q.size() == 0; c++) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL timeout_beats got=%0d exp=1", got_q.size()); end
`else
    repeat (1000) tick();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL no_timeout_beats got=%0d exp=0", got_q.size()); end
    checks++; if (bus.dct_valid !== 1'b0) begin errors++; $display("FAIL no_timeout_valid got=%0b exp=0", bus.dct_valid); end
    pulse_flush();
    wait_beats(1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL timeout_flush_beats got=%0d exp=1", got_q.size()); end
`endif
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++; if (g !== {4'd1, 30'h00000002}) begin errors++; $display("FAIL timeout_beat got=%h exp=%h", g, {4'd1, 30'h00000002}); end
    end
    repeat (3) tick();
    got_q.delete();
  endtask

  task automatic test_end();
    int st;
    logic found;
    logic [CNT_W+BUF_W-1:0] g;
    bus.dct_ready = 1'b1;
    offer(ATOM_3, st); offer(ATOM_2, st); offer(ATOM_1, st); offer(ATOM_0, st); offer(ATOM_3, st);
    bus.end_req = 1'b1;
    tick();
    bus.end_req = 1'b0;
    checks++; if (bus.test_ending !== 1'b1) begin errors++; $display("FAIL end_test_ending got=%0b exp=1", bus.test_ending); end
    checks++; if (bus.atom_ready !== 1'b0) begin errors++; $display("FAIL end_atom_ready got=%0b exp=0", bus.atom_ready); end
    checks++; if (bus.test_has_ended !== 1'b0) begin errors++; $display("FAIL end_has_ended_early got=%0b exp=0", bus.test_has_ended); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.dct_valid && bus.dct_ready) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL end_beat_seen got=0 exp=1"); end
    tick();
    checks++; if (bus.test_has_ended !== 1'b0) begin errors++; $display("FAIL end_has_ended_at_hs got=%0b exp=0", bus.test_has_ended); end
    tick();
    checks++; if (bus.test_has_ended !== 1'b1) begin errors++; $display("FAIL end_has_ended got=%0b exp=1", bus.test_has_ended); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL end_beats got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++; if (g !== {4'd5, 30'h0000031B}) begin errors++; $display("FAIL end_beat got=%h exp=%h", g, {4'd5, 30'h0000031B}); end
    end
    // Requests in DONE are ignored and the status stays sticky.
    bus.atom_valid = 1'b1; bus.atom = ATOM_1; bus.flush = 1'b1; bus.end_req = 1'b1;
    repeat (10) tick();
    bus.atom_valid = 1'b0; bus.flush = 1'b0; bus.end_req = 1'b0;
    repeat (5) tick();
    checks++; if (bus.test_has_ended !== 1'b1) begin errors++; $display("FAIL done_has_ended got=%0b exp=1", bus.test_has_ended); end
    checks++; if (bus.test_ending !== 1'b1) begin errors++; $display("FAIL done_test_ending got=%0b exp=1", bus.test_ending); end
    checks++; if (bus.atom_ready !== 1'b0) begin errors++; $display("FAIL done_atom_ready got=%0b exp=0", bus.atom_ready); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL done_beats got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    int st;
    logic [CNT_W+BUF_W-1:0] g;
    apply_reset();
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 15; i++) offer(ATOM_2, st);
    tick();
    checks++; if (bus.dct_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_valid got=%0b exp=1", bus.dct_valid); end
    bus.end_req = 1'b1;
    tick();
    bus.end_req = 1'b0;
    checks++; if (bus.test_ending !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_ending got=%0b exp=1", bus.test_ending); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.dct_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.dct_valid); end
    checks++; if (bus.test_ending !== 1'b0) begin errors++; $display("FAIL rst_mid_ending got=%0b exp=0", bus.test_ending); end
    checks++; if (bus.test_has_ended !== 1'b0) begin errors++; $display("FAIL rst_mid_has_ended got=%0b exp=0", bus.test_has_ended); end
    tick();
    reset_n = 1'b1;
    init_inputs();
    tick();
    got_q.delete();
    offer(ATOM_3, st); offer(ATOM_3, st); offer(ATOM_3, st);
    pulse_flush();
    wait_beats(1);
    repeat (3) tick();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL rst_mid_beats got=%0d exp=1", got_q.size()); end
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      checks++; if (g !== {4'd3, 30'h0000003F}) begin errors++; $display("FAIL rst_mid_beat got=%h exp=%h", g, {4'd3, 30'h0000003F}); end
    end
    got_q.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    init_inputs();
    test_reset();
    test_full_buffer();
    test_flush();
    test_back_to_back();
    test_timeout();
    test_end();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
